// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack fetch bus
//   req   : fetch request, held until ack
//   addr  : fetch address
//   ack   : rdata valid this cycle
//   rdata : instruction word
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS fetch stage; optional PC_MISALIGN_TRAP_EN halts on misaligned targets
//   clk, rst_n    : clock, async active-low reset
//   im            : instruction-memory fetch bus (master side)
//   next_pc_sel   : 00 pc+4, 01 branch, 10 jump, 11 jump register
//   stall         : hold the instruction in EXEC
//   jr_addr       : jump-register target
//   pc, instr     : current PC and latched instruction
//   opcode, funct : instr[31:26], instr[5:0]
//   instr_valid   : instr is executing
//   retired       : completed-instruction count
//   misalign      : sticky misaligned-target flag
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master im,
    input  logic [1:0]  next_pc_sel,
    input  logic        stall,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] retired,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
    state_t state, state_nxt;
    logic [31:0] p4, npc_raw, npc;
    logic bad, exit_exec;
    assign p4 = pc + 32'd4;
    assign npc_raw = next_pc_sel == 2'b00 ? p4 :
                     next_pc_sel == 2'b01 ? p4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                     next_pc_sel == 2'b10 ? {p4[31:28], instr[25:0], 2'b00} : jr_addr;
`ifdef PC_MISALIGN_TRAP_EN
    assign npc = npc_raw;
    assign bad = |npc_raw[1:0];
`else
    assign npc = npc_raw & ~32'h3;
    assign bad = 1'b0;
`endif
    assign exit_exec   = state == EXEC && !stall;
    assign im.req      = state == FETCH;
    assign im.addr     = pc;
    assign instr_valid = state == EXEC;
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = im.ack ? EXEC : FETCH;
            EXEC:    state_nxt = stall ? EXEC : (bad ? HALT : FETCH);
            default: state_nxt = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && im.ack) instr <= im.rdata;
            if (exit_exec && !bad) begin
                pc      <= npc;
                retired <= retired + 32'd1;
            end
        end
    end
`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign <= 1'b0;
        else if (exit_exec && bad) misalign <= 1'b1;
    end
`else
    assign misalign = 1'b0;
`endif
endmodule
